// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types for the CPU data-bus target: the queued request record, the
// responder state encoding and an address-window helper.
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

  // All four byte lanes enabled
  localparam logic [3:0] BE_WORD = 4'hF;

  // One queued bus transaction
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } dmem_state_t;

  // True when a byte offset (already rebased to the window start) lies
  // inside a window of 2**words_log2 32-bit words. The subtraction that
  // produces the offset is 32-bit unsigned, so addresses below the window
  // become huge offsets and are rejected here as well.
  function automatic logic offset_in_window(input logic [31:0] offset,
                                            input int unsigned words_log2);
    offset_in_window = ((offset >> (words_log2 + 32'd2)) == 32'd0);
  endfunction

endpackage

// File: rtl/cpu_req_fifo.sv
// ---------------------------------------------------------------------------
// cpu_req_fifo
// Request queue between the CPU data port and the SRAM sequencer.
// Pointers carry one extra MSB so full and empty are distinguished without a
// separate counter. Only the pointers are reset; payload storage is not.
// The caller must not push while full unless it pops in the same cycle.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   i_push, i_data : write a request
//   i_pop          : retire the head entry (ignored when empty)
//   o_data         : head entry
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored entries
// ---------------------------------------------------------------------------
module cpu_req_fifo
  import cpu_bus_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      i_push,
  input  bus_req_t                  i_data,
  input  logic                      i_pop,
  output bus_req_t                  o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(QDEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(QDEPTH);

  bus_req_t       r_store [QDEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_do_pop;

  assign w_do_pop = i_pop && !o_empty;

  // Payload storage, written at the tail
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_store[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Read and write pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_data  = r_store[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot index but different lap bit means the writer is a full lap ahead
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/cpu_dmem_responder.sv
// ---------------------------------------------------------------------------
// cpu_dmem_responder
// Target end of the CPU data bus. Single-cycle request pulses are queued and
// served strictly in order against an on-chip word-wide SRAM built from four
// byte-lane arrays, with WAIT_STATES idle cycles before each access. Every
// accepted request gets exactly one ack pulse; out-of-window accesses are
// acked with range_error and never touch the SRAM.
// Ports:
//   clock, reset_n    : clock, asynchronous active-low reset
//   cpud_request      : one-cycle pulse, new transaction
//   cpud_addr         : byte address (bits [1:0] ignored)
//   cpud_write        : 1 = write, 0 = read
//   cpud_byte_enable  : write lane enables
//   cpud_wdata        : write data
//   cpud_rdata        : read data, valid with cpud_ack, held until next ack
//   cpud_ack          : one pulse per accepted request, in order
//   range_error       : pulses with the ack of an out-of-window access
//   queue_overflow    : sticky, a request was dropped on a full queue
// ---------------------------------------------------------------------------
module cpu_dmem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WORDS_LOG2  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpud_request,
  input  logic [31:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        range_error,
  output logic        queue_overflow
);

  localparam int unsigned SRAM_WORDS = 2**WORDS_LOG2;
  localparam int unsigned CW         = $clog2(QDEPTH) + 1;
  // Counter preload so that WAIT lasts exactly WAIT_STATES cycles
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  // State entered whenever there is work at the queue head
  localparam dmem_state_t START_STATE = (WAIT_STATES > 0) ? WAIT : ACCESS;

  dmem_state_t            r_state;
  logic [3:0]             r_wait_cnt;

  bus_req_t               w_new_req;
  bus_req_t               w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_more;
  logic [31:0]            w_offset;
  logic                   w_in_range;
  logic [WORDS_LOG2-1:0]  w_word_idx;
  logic                   w_wr_en;
  logic [7:0]             w_rd_lane [4];
  logic [31:0]            w_rd_word;

  assign w_new_req = '{addr:  cpud_addr,
                       write: cpud_write,
                       be:    cpud_byte_enable,
                       wdata: cpud_wdata};

  // The head is retired in every ACCESS cycle
  assign w_pop  = (r_state == ACCESS);
  // A full queue still accepts when the head leaves on the same edge
  assign w_push = cpud_request && (!w_full || w_pop);
  assign w_drop = cpud_request && w_full && !w_pop;
  // Work left for the next cycle; a same-edge push is not visible yet
  assign w_more = w_pop ? (w_count > CW'(1)) : !w_empty;

  cpu_req_fifo #(
    .QDEPTH (QDEPTH)
  ) u_req_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_new_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Rebase to the window start with 32-bit unsigned wrap
  assign w_offset   = w_head.addr - BASE_ADDR;
  assign w_in_range = offset_in_window(w_offset, WORDS_LOG2);
  assign w_word_idx = w_offset[WORDS_LOG2+1:2];
  assign w_wr_en    = (r_state == ACCESS) && w_head.write && w_in_range;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] r_mem [SRAM_WORDS];

    // Byte-lane SRAM write; reset_n guards against completing a write
    // on the edge where reset is asserted
    always_ff @(posedge clock) begin
      if (reset_n && w_wr_en && w_head.be[l]) begin
        r_mem[w_word_idx] <= w_head.wdata[8*l +: 8];
      end
    end

    assign w_rd_lane[l] = r_mem[w_word_idx];
  end

  assign w_rd_word = {w_rd_lane[3], w_rd_lane[2], w_rd_lane[1], w_rd_lane[0]};

  // Sequencer with registered ack, read data and error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_wait_cnt     <= 4'd0;
      cpud_ack       <= 1'b0;
      cpud_rdata     <= 32'd0;
      range_error    <= 1'b0;
      queue_overflow <= 1'b0;
    end else begin
      cpud_ack    <= 1'b0;
      range_error <= 1'b0;
      if (w_drop) begin
        queue_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= START_STATE;
            r_wait_cnt <= WAIT_LOAD;
          end else begin
            r_state    <= IDLE;
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state    <= ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ACCESS: begin
          cpud_ack    <= 1'b1;
          range_error <= !w_in_range;
          // Writes and rejected accesses return zero; reads return the word
          if (!w_head.write && w_in_range) begin
            cpud_rdata <= w_rd_word;
          end else begin
            cpud_rdata <= 32'd0;
          end
          if (w_more) begin
            r_state    <= START_STATE;
            r_wait_cnt <= WAIT_LOAD;
          end else begin
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
